alu_secuencial: RTL and testbench

Registered, parametrised ALU with operand width ANCHO and a start/valid handshake. Keeps the 3-bit opcode set (SUM, RES, PRO, DIV, MOD, AND, OR, XOR). DIV and MOD use an iterative restoring divider, one quotient bit per cycle. Sits between the operand/opcode source and the result consumer; accepts one operation at a time.

---
 rtl/alu_secuencial.sv | 191 +++++++++++++++++++
 tb/tb_alu_secuencial.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_secuencial.sv
// alu_secuencial: registered unsigned ALU with a start/valid handshake.
// DIV/MOD use an iterative restoring divider (one quotient bit per cycle).
// Optional macro ALU_MULT_ITER_EN: PRO is computed by an iterative shift-add
// multiplier instead of a single-cycle combinational product.
module alu_secuencial #(
    parameter int ANCHO = 8
) (
    input  logic               reloj,
    input  logic               reinicio_n,
    input  logic               inicio,
    input  logic [2:0]         Codigo_OP,
    input  logic [ANCHO-1:0]   Dato0,
    input  logic [ANCHO-1:0]   Dato1,
    output logic               listo,
    output logic               valido,
    output logic [2*ANCHO-1:0] Resultado,
    output logic               banderaA,
    output logic               banderaB,
    output logic               banderaC
);

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_RES = 3'd1;
    localparam logic [2:0] OP_PRO = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    localparam int CW = $clog2(ANCHO);
    localparam logic [CW-1:0] ULTIMA = CW'(ANCHO - 1);

    typedef enum logic [1:0] {LIBRE, CALCULA, ENTREGA} estado_t;

    estado_t            estado, estado_sig;
    logic [2:0]         op_q;
    logic [ANCHO-1:0]   a_q, b_q;
    logic [ANCHO-1:0]   coc_q;     // dividend shifting out, quotient shifting in
    logic [ANCHO-1:0]   rem_q;     // partial remainder, always < b_q
    logic [CW-1:0]      cnt_q;
    logic               acepta, iterativa;
    logic [ANCHO:0]     prueba;
    logic [ANCHO:0]     suma;
    logic [2*ANCHO-1:0] final_res;
    logic               final_a, final_c;
`ifdef ALU_MULT_ITER_EN
    logic [2*ANCHO-1:0] prod_q, mcand_q;
    logic [ANCHO-1:0]   mplier_q;
`endif

    assign listo  = (estado == LIBRE);
    assign acepta = inicio && (estado == LIBRE);
    // Shift next dividend bit into the partial remainder for the trial subtract.
    assign prueba = {rem_q, coc_q[ANCHO-1]};

    // Decide whether the incoming opcode needs the multi-cycle path.
    always_comb begin
        iterativa = ((Codigo_OP == OP_DIV) || (Codigo_OP == OP_MOD)) && (Dato1 != '0);
`ifdef ALU_MULT_ITER_EN
        if (Codigo_OP == OP_PRO) iterativa = 1'b1;
`endif
    end

    // State register.
    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) estado <= LIBRE;
        else             estado <= estado_sig;
    end

    // Next-state logic.
    always_comb begin
        estado_sig = estado;
        case (estado)
            LIBRE:   if (acepta) estado_sig = iterativa ? CALCULA : ENTREGA;
            CALCULA: if (cnt_q == ULTIMA) estado_sig = ENTREGA;
            ENTREGA: estado_sig = LIBRE;
            default: estado_sig = LIBRE;
        endcase
    end

    // Operand capture on acceptance and one iteration per CALCULA cycle.
    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            coc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
`ifdef ALU_MULT_ITER_EN
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else if (acepta) begin
            op_q     <= Codigo_OP;
            a_q      <= Dato0;
            b_q      <= Dato1;
            coc_q    <= Dato0;
            rem_q    <= '0;
            cnt_q    <= '0;
`ifdef ALU_MULT_ITER_EN
            prod_q   <= '0;
            mcand_q  <= {{ANCHO{1'b0}}, Dato0};
            mplier_q <= Dato1;
`endif
        end else if (estado == CALCULA) begin
            cnt_q <= cnt_q + CW'(1);
            if (prueba >= {1'b0, b_q}) begin
                rem_q <= prueba[ANCHO-1:0] - b_q;
                coc_q <= {coc_q[ANCHO-2:0], 1'b1};
            end else begin
                rem_q <= prueba[ANCHO-1:0];
                coc_q <= {coc_q[ANCHO-2:0], 1'b0};
            end
`ifdef ALU_MULT_ITER_EN
            if (mplier_q[0]) prod_q <= prod_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
`endif
        end
    end

    // Final result and flags from the latched operation.
    always_comb begin
        final_res = '0;
        final_a   = 1'b0;
        final_c   = 1'b0;
        suma      = '0;
        case (op_q)
            OP_SUM: begin
                suma              = {1'b0, a_q} + {1'b0, b_q};
                final_res[ANCHO:0] = suma;
                final_a           = suma[ANCHO];
            end
            OP_RES: begin
                suma              = {1'b0, a_q} - {1'b0, b_q};
                final_res[ANCHO:0] = suma;
                final_a           = suma[ANCHO];
            end
            OP_PRO: begin
`ifdef ALU_MULT_ITER_EN
                final_res = prod_q;
`else
                final_res = {{ANCHO{1'b0}}, a_q} * {{ANCHO{1'b0}}, b_q};
`endif
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    final_res = '1;
                    final_c   = 1'b1;
                end else begin
                    final_res[ANCHO-1:0] = coc_q;
                end
            end
            OP_MOD: begin
                if (b_q == '0) begin
                    final_res[ANCHO-1:0] = a_q;
                    final_c              = 1'b1;
                end else begin
                    final_res[ANCHO-1:0] = rem_q;
                end
            end
            OP_AND:  final_res[ANCHO-1:0] = a_q & b_q;
            OP_OR:   final_res[ANCHO-1:0] = a_q | b_q;
            OP_XOR:  final_res[ANCHO-1:0] = a_q ^ b_q;
            default: final_res = '0;
        endcase
    end

    // Output registers: load and pulse valido when leaving ENTREGA, else hold.
    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            valido    <= 1'b0;
            Resultado <= '0;
            banderaA  <= 1'b0;
            banderaB  <= 1'b0;
            banderaC  <= 1'b0;
        end else begin
            valido <= (estado == ENTREGA);
            if (estado == ENTREGA) begin
                Resultado <= final_res;
                banderaA  <= final_a;
                banderaB  <= (final_res == '0);
                banderaC  <= final_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_secuencial.sv
// Testbench for alu_secuencial: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_alu_secuencial;

    localparam int ANCHO = 8;
`ifdef ALU_MULT_ITER_EN
    localparam int LAT_PRO = ANCHO + 1;
`else
    localparam int LAT_PRO = 1;
`endif

    logic               reloj = 1'b0;
    logic               reinicio_n;
    logic               inicio;
    logic [2:0]         Codigo_OP;
    logic [ANCHO-1:0]   Dato0, Dato1;
    logic               listo, valido;
    logic [2*ANCHO-1:0] Resultado;
    logic               banderaA, banderaB, banderaC;

    int n_checks = 0;
    int n_err    = 0;

    alu_secuencial #(.ANCHO(ANCHO)) dut (
        .reloj      (reloj),
        .reinicio_n (reinicio_n),
        .inicio     (inicio),
        .Codigo_OP  (Codigo_OP),
        .Dato0      (Dato0),
        .Dato1      (Dato1),
        .listo      (listo),
        .valido     (valido),
        .Resultado  (Resultado),
        .banderaA   (banderaA),
        .banderaB   (banderaB),
        .banderaC   (banderaC)
    );

    always #5 reloj = ~reloj;

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definition.
    task automatic modelo(input int op, input int a, input int b,
                          output int r, output bit fa, output bit fc);
        fa = 1'b0;
        fc = 1'b0;
        r  = 0;
        case (op)
            0: begin r = a + b; fa = (a + b) >= (1 << ANCHO); end
            1: begin r = (a - b + (2 << ANCHO)) % (2 << ANCHO); fa = (a < b); end
            2: r = a * b;
            3: if (b == 0) begin r = (1 << (2 * ANCHO)) - 1; fc = 1'b1; end
               else r = a / b;
            4: if (b == 0) begin r = a; fc = 1'b1; end
               else r = a % b;
            5: r = a & b;
            6: r = a | b;
            default: r = a ^ b;
        endcase
    endtask

    // Issue one operation from a negedge; returns at the negedge where valido is seen.
    task automatic run_op(input int op, input int a, input int b, input bit hold);
        int  r, lat, lat_esp;
        bit  fa, fc, got, busy_bad;
        modelo(op, a, b, r, fa, fc);
        if ((op == 3 || op == 4) && b != 0) lat_esp = ANCHO + 1;
        else if (op == 2)                   lat_esp = LAT_PRO;
        else                                lat_esp = 1;
        inicio    = 1'b1;
        Codigo_OP = 3'(op);
        Dato0     = ANCHO'(a);
        Dato1     = ANCHO'(b);
        @(posedge reloj);
        #1;
        if (!hold) inicio = 1'b0;
        Codigo_OP = 3'($urandom);
        Dato0     = ANCHO'($urandom);
        Dato1     = ANCHO'($urandom);
        lat = 0; got = 1'b0; busy_bad = 1'b0;
        while (!got && lat < 40) begin
            @(negedge reloj);
            if (valido) got = 1'b1;
            else begin
                if (listo) busy_bad = 1'b1;
                if (hold) begin
                    Codigo_OP = 3'($urandom);
                    Dato0     = ANCHO'($urandom);
                    Dato1     = ANCHO'($urandom);
                end
                @(posedge reloj);
                lat++;
            end
        end
        inicio = 1'b0;
        verifica("valido_seen", 64'(got), 64'd1);
        if (got) begin
            verifica("latency",   64'(lat), 64'(lat_esp));
            verifica("busy_listo", 64'(busy_bad), 64'd0);
            verifica("resultado", 64'(Resultado), 64'(r));
            verifica("banderaA",  64'(banderaA), 64'(fa));
            verifica("banderaB",  64'(banderaB), 64'(r == 0));
            verifica("banderaC",  64'(banderaC), 64'(fc));
            verifica("listo_on_valido", 64'(listo), 64'd1);
        end
    endtask

    initial begin
        bit extra_v;
        logic [2*ANCHO-1:0] held;
        reinicio_n = 1'b0;
        inicio     = 1'b0;
        Codigo_OP  = '0;
        Dato0      = '0;
        Dato1      = '0;
        repeat (2) @(negedge reloj);
        verifica("rst_listo",  64'(listo), 64'd1);
        verifica("rst_valido", 64'(valido), 64'd0);
        verifica("rst_res",    64'(Resultado), 64'd0);
        verifica("rst_flags",  64'({banderaA, banderaB, banderaC}), 64'd0);
        reinicio_n = 1'b1;
        @(negedge reloj);

        run_op(0, 200, 100, 1'b0);
        verifica("sum_const", 64'(Resultado), 64'h012C);
        @(negedge reloj);
        verifica("valido_one_cycle", 64'(valido), 64'd0);

        run_op(1, 5, 7, 1'b0);
        verifica("res_const", 64'(Resultado), 64'h01FE);
        run_op(1, 7, 7, 1'b0);   // accepted on the valido cycle

        run_op(3, 200, 7, 1'b1); // inicio held high with changing operands
        verifica("div_const", 64'(Resultado), 64'd28);
        extra_v = 1'b0;
        held = Resultado;
        repeat (4) begin
            @(negedge reloj);
            if (valido || !listo) extra_v = 1'b1;
        end
        verifica("no_extra_valido", 64'(extra_v), 64'd0);
        verifica("result_held", 64'(Resultado), 64'(held));

        run_op(4, 200, 7, 1'b0);
        verifica("mod_const", 64'(Resultado), 64'd4);
        run_op(3, 55, 0, 1'b0);
        run_op(4, 55, 0, 1'b0);
        run_op(2, 255, 255, 1'b0);
        verifica("pro_const", 64'(Resultado), 64'hFE01);

        // Asynchronous reset in the middle of a division.
        @(negedge reloj);
        inicio = 1'b1; Codigo_OP = 3'd3; Dato0 = 8'd200; Dato1 = 8'd7;
        @(posedge reloj);
        #1 inicio = 1'b0;
        repeat (3) @(posedge reloj);
        #3 reinicio_n = 1'b0;
        #1;
        verifica("arst_res",    64'(Resultado), 64'd0);
        verifica("arst_listo",  64'(listo), 64'd1);
        verifica("arst_valido", 64'(valido), 64'd0);
        verifica("arst_flags",  64'({banderaA, banderaB, banderaC}), 64'd0);
        @(negedge reloj);
        reinicio_n = 1'b1;
        extra_v = 1'b0;
        repeat (ANCHO + 3) begin
            @(negedge reloj);
            if (valido) extra_v = 1'b1;
        end
        verifica("arst_no_valido", 64'(extra_v), 64'd0);
        run_op(5, 8'hF0, 8'h0F, 1'b0);

        // Randomized operations, some back-to-back, some with idle gaps.
        for (int i = 0; i < 60; i++) begin
            int op, a, b;
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, (1 << ANCHO) - 1));
            b  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, (1 << ANCHO) - 1));
            if ($urandom_range(0, 2) == 0) a = (1 << ANCHO) - 1;
            run_op(op, a, b, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge reloj);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
